// File: rtl/ex_mem_flags_if.sv
// EX -> MEM boundary bundle for ex_mem_flags.
// master: EX-stage side (drives instruction fields, observes MEM outputs).
// slave : the EX/MEM register itself.
interface ex_mem_flags_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [3:0]    opcode;
    logic [DW-1:0] alu_result;
    logic          ovf_in;
    logic [DW-1:0] st_data_in;
    logic [RW-1:0] dst_in;
    logic          reg_wr_in;
    logic          mem_rd_in;
    logic          mem_wr_in;

    logic          valid_out;
    logic [DW-1:0] result_out;
    logic [DW-1:0] st_data_out;
    logic [RW-1:0] dst_out;
    logic          reg_wr_out;
    logic          mem_rd_out;
    logic          mem_wr_out;
    logic [2:0]    flags_out;
    logic          halted;

    modport master (
        output stall, flush, in_valid, opcode, alu_result, ovf_in,
               st_data_in, dst_in, reg_wr_in, mem_rd_in, mem_wr_in,
        input  valid_out, result_out, st_data_out, dst_out,
               reg_wr_out, mem_rd_out, mem_wr_out, flags_out, halted
    );

    modport slave (
        input  stall, flush, in_valid, opcode, alu_result, ovf_in,
               st_data_in, dst_in, reg_wr_in, mem_rd_in, mem_wr_in,
        output valid_out, result_out, st_data_out, dst_out,
               reg_wr_out, mem_rd_out, mem_wr_out, flags_out, halted
    );
endinterface

// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline register with the architectural {N,Z,V} flag register and
// sticky halt tracking.
// Optional macro FLAG_BYPASS_EN: when defined, flags_out forwards the flags
// being written this cycle so a branch right after ADD/SUB/XOR needs no stall.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal operation, instructions captured from EX
// HALTED  | HLT reached MEM; further instructions ignored until reset
module ex_mem_flags #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ex_mem_flags_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_valid;
    logic [DW-1:0] r_result;
    logic [DW-1:0] r_st_data;
    logic [RW-1:0] r_dst;
    logic          r_reg_wr;
    logic          r_mem_rd;
    logic          r_mem_wr;
    logic [2:0]    r_flags;

    logic          w_cap;
    logic          w_is_hlt;
    logic          w_we_gate;
    logic [2:0]    w_flags_nxt;

    // Capture qualifier; an HLT travels as a valid instruction but never writes.
    always_comb begin
        w_cap     = bus.in_valid & ~bus.stall & ~bus.flush & (r_state == RUN);
        w_is_hlt  = (bus.opcode == OP_HLT);
        w_we_gate = w_cap & ~w_is_hlt;
    end

    // Next state: a captured HLT parks the stage in HALTED until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_cap && w_is_hlt) w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    // Flag values this cycle's capture would write; equals r_flags otherwise.
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_cap) begin
            case (bus.opcode)
                OP_ADD, OP_SUB: begin
                    w_flags_nxt[2] = bus.alu_result[DW-1];
                    w_flags_nxt[1] = (bus.alu_result == '0);
                    w_flags_nxt[0] = bus.ovf_in;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    w_flags_nxt[1] = (bus.alu_result == '0);
                end
                default: w_flags_nxt = r_flags;
            endcase
        end
    end

    // Pipeline, flag and state registers; everything holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_st_data <= '0;
            r_dst     <= '0;
            r_reg_wr  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_flags   <= 3'b000;
        end else if (!bus.stall) begin
            r_state   <= w_state_nxt;
            r_valid   <= w_cap;
            r_result  <= bus.alu_result;
            r_st_data <= bus.st_data_in;
            r_dst     <= bus.dst_in;
            r_reg_wr  <= bus.reg_wr_in & w_we_gate;
            r_mem_rd  <= bus.mem_rd_in & w_we_gate;
            r_mem_wr  <= bus.mem_wr_in & w_we_gate;
            r_flags   <= w_flags_nxt;
        end
    end

    // Output mapping; the bypass path falls back to the register on stall/flush.
    always_comb begin
        bus.valid_out   = r_valid;
        bus.result_out  = r_result;
        bus.st_data_out = r_st_data;
        bus.dst_out     = r_dst;
        bus.reg_wr_out  = r_reg_wr;
        bus.mem_rd_out  = r_mem_rd;
        bus.mem_wr_out  = r_mem_wr;
        bus.halted      = (r_state == HALTED);
`ifdef FLAG_BYPASS_EN
        bus.flags_out   = (bus.stall | bus.flush) ? r_flags : w_flags_nxt;
`else
        bus.flags_out   = r_flags;
`endif
    end

endmodule

// File: tb/tb_ex_mem_flags.sv
module tb_ex_mem_flags;

    localparam int DW = 16;
    localparam int RW = 4;

    logic clk;
    logic rst_n;

    ex_mem_flags_if #(.DW(DW), .RW(RW)) bus ();

    ex_mem_flags #(.DW(DW), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] alu;
        logic          ovf;
        logic [DW-1:0] st;
        logic [RW-1:0] dst;
        logic          rw, mr, mw, iv, stl, fl;
        logic          e_v;
        logic [DW-1:0] e_res;
        logic [DW-1:0] e_st;
        logic [RW-1:0] e_dst;
        logic          e_rw, e_mr, e_mw;
        logic [2:0]    e_flags;
        logic          e_h;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.opcode     = 4'h0;
        bus.alu_result = '0;
        bus.ovf_in     = 1'b0;
        bus.st_data_in = '0;
        bus.dst_in     = '0;
        bus.reg_wr_in  = 1'b0;
        bus.mem_rd_in  = 1'b0;
        bus.mem_wr_in  = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] alu, input logic ovf,
                         input logic iv, input logic rw, input logic stl, input logic fl);
        bus.opcode     = op;
        bus.alu_result = alu;
        bus.ovf_in     = ovf;
        bus.in_valid   = iv;
        bus.reg_wr_in  = rw;
        bus.mem_rd_in  = 1'b0;
        bus.mem_wr_in  = 1'b0;
        bus.st_data_in = '0;
        bus.dst_in     = '0;
        bus.stall      = stl;
        bus.flush      = fl;
    endtask

    initial begin
        //           op     alu       ov st       dst  rw mr mw iv st fl | v  res       st        dst  rw mr mw flags   h
        vecs[0]  = '{4'h0, 16'h0000, 0, 16'h0000, 4'h1, 1, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 4'h1, 1, 0, 0, 3'b010, 0};
        vecs[1]  = '{4'h1, 16'h8001, 1, 16'h0000, 4'h2, 1, 0, 0, 1, 0, 0, 1, 16'h8001, 16'h0000, 4'h2, 1, 0, 0, 3'b101, 0};
        vecs[2]  = '{4'h3, 16'h0021, 0, 16'h0000, 4'h3, 1, 0, 0, 1, 0, 0, 1, 16'h0021, 16'h0000, 4'h3, 1, 0, 0, 3'b101, 0};
        vecs[3]  = '{4'h2, 16'h0000, 0, 16'h0000, 4'h4, 1, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 4'h4, 1, 0, 0, 3'b111, 0};
        vecs[4]  = '{4'h0, 16'h1234, 0, 16'h0000, 4'h5, 1, 0, 0, 1, 1, 1, 1, 16'h0000, 16'h0000, 4'h4, 1, 0, 0, 3'b111, 0};
        vecs[5]  = '{4'h0, 16'h1234, 0, 16'h0000, 4'h6, 1, 0, 1, 1, 0, 1, 0, 16'h1234, 16'h0000, 4'h6, 0, 0, 0, 3'b111, 0};
        vecs[6]  = '{4'h9, 16'h0040, 0, 16'h00AA, 4'h7, 0, 0, 1, 1, 0, 0, 1, 16'h0040, 16'h00AA, 4'h7, 0, 0, 1, 3'b111, 0};
        vecs[7]  = '{4'h4, 16'h8000, 0, 16'h0000, 4'h8, 1, 0, 0, 1, 0, 0, 1, 16'h8000, 16'h0000, 4'h8, 1, 0, 0, 3'b101, 0};
        vecs[8]  = '{4'h8, 16'h0000, 0, 16'h0000, 4'h9, 1, 1, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 4'h9, 1, 1, 0, 3'b101, 0};
        vecs[9]  = '{4'h0, 16'h0000, 0, 16'h0000, 4'hA, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'hA, 0, 0, 0, 3'b101, 0};
        vecs[10] = '{4'h0, 16'h7FFF, 0, 16'h0000, 4'hB, 1, 0, 0, 1, 0, 0, 1, 16'h7FFF, 16'h0000, 4'hB, 1, 0, 0, 3'b000, 0};
        vecs[11] = '{4'hF, 16'h0000, 0, 16'h0000, 4'hC, 1, 1, 1, 1, 0, 0, 1, 16'h0000, 16'h0000, 4'hC, 0, 0, 0, 3'b000, 1};
        vecs[12] = '{4'h0, 16'h0000, 0, 16'h0000, 4'hD, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 4'hD, 0, 0, 0, 3'b000, 1};
        vecs[13] = '{4'h0, 16'h5555, 0, 16'h0000, 4'hE, 1, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 4'hD, 0, 0, 0, 3'b000, 1};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_valid",  32'(bus.valid_out),   32'h0);
        chk("rst_result", 32'(bus.result_out),  32'h0);
        chk("rst_st",     32'(bus.st_data_out), 32'h0);
        chk("rst_dst",    32'(bus.dst_out),     32'h0);
        chk("rst_we",     32'({bus.reg_wr_out, bus.mem_rd_out, bus.mem_wr_out}), 32'h0);
        chk("rst_flags",  32'(bus.flags_out),   32'h0);
        chk("rst_halted", 32'(bus.halted),      32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.opcode     = vecs[i].op;
            bus.alu_result = vecs[i].alu;
            bus.ovf_in     = vecs[i].ovf;
            bus.st_data_in = vecs[i].st;
            bus.dst_in     = vecs[i].dst;
            bus.reg_wr_in  = vecs[i].rw;
            bus.mem_rd_in  = vecs[i].mr;
            bus.mem_wr_in  = vecs[i].mw;
            bus.in_valid   = vecs[i].iv;
            bus.stall      = vecs[i].stl;
            bus.flush      = vecs[i].fl;
            @(posedge clk);
            #1;
            // Drop the instruction so a forwarding build shows the register.
            bus.in_valid = 1'b0;
            bus.stall    = 1'b0;
            bus.flush    = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i),  32'(bus.valid_out),   32'(vecs[i].e_v));
            chk($sformatf("v%0d_result", i), 32'(bus.result_out),  32'(vecs[i].e_res));
            chk($sformatf("v%0d_st", i),     32'(bus.st_data_out), 32'(vecs[i].e_st));
            chk($sformatf("v%0d_dst", i),    32'(bus.dst_out),     32'(vecs[i].e_dst));
            chk($sformatf("v%0d_reg_wr", i), 32'(bus.reg_wr_out),  32'(vecs[i].e_rw));
            chk($sformatf("v%0d_mem_rd", i), 32'(bus.mem_rd_out),  32'(vecs[i].e_mr));
            chk($sformatf("v%0d_mem_wr", i), 32'(bus.mem_wr_out),  32'(vecs[i].e_mw));
            chk($sformatf("v%0d_flags", i),  32'(bus.flags_out),   32'(vecs[i].e_flags));
            chk($sformatf("v%0d_halted", i), 32'(bus.halted),      32'(vecs[i].e_h));
        end

        // Asynchronous reset in the middle of HALTED, away from any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_halted", 32'(bus.halted),     32'h0);
        chk("arst_valid",  32'(bus.valid_out),  32'h0);
        chk("arst_dst",    32'(bus.dst_out),    32'h0);
        chk("arst_flags",  32'(bus.flags_out),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back in RUN: ADD result zero.
        @(negedge clk);
        drive(4'h0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("run_valid", 32'(bus.valid_out), 32'h1);
        chk("run_flags", 32'(bus.flags_out), 32'h2);

        // Flag timing relative to the capturing edge: ADD 0x8000 with V set.
        @(negedge clk);
        drive(4'h0, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
`ifdef FLAG_BYPASS_EN
        chk("byp_same_cycle", 32'(bus.flags_out), 32'h5);
`else
        chk("byp_same_cycle", 32'(bus.flags_out), 32'h2);
`endif
        // Stall suppresses any forwarding and holds the register.
        bus.stall = 1'b1;
        #1;
        chk("byp_stall", 32'(bus.flags_out), 32'h2);
        @(posedge clk);
        #1;
        chk("byp_stall_hold", 32'(bus.flags_out), 32'h2);
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        drive(4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("byp_next_cycle", 32'(bus.flags_out), 32'h5);

        // Reset while stalled also clears everything.
        @(negedge clk);
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall_valid",  32'(bus.valid_out),  32'h0);
        chk("arst_stall_result", 32'(bus.result_out), 32'h0);
        chk("arst_stall_flags",  32'(bus.flags_out),  32'h0);
        @(negedge clk);
        bus.stall = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
